snn_rate_encoder: RTL
=====================

// Module: snn_rate_encoder
// PURPOSE
//  Encoder stage started by the accelerator control FSM (enc_start level, enc_done pulse).
//  Converts N_PIX pixels from the pre-processing buffer into T_STEPS spike words.
//  Each spike word holds one bit per pixel and is written to the spike buffer that the SNN core reads.
//  Two modes: stochastic rate coding (LFSR compare) and deterministic threshold coding.
// PARAMETERS
//  N_PIX     16      pixels per frame; also the spike word width
//  PIX_W     8       pixel width (bits); must be <= 16
//  T_STEPS   8       timesteps generated per job
//  THRESH    128     threshold used in mode 01
//  LFSR_SEED 16'hACE1 LFSR reload value; must be non-zero
// PORTS
//  clk        in   1                     clock; all logic on rising edge
//  rst        in   1                     synchronous reset, active-high
//  enc_start  in   1                     level start from the ctrl FSM; held high until after enc_done
//  enc_mode   in   2                     00 rate, 01 threshold, 10/11 rate; latched at job start
//  pix_rd_en  out  1                     pixel buffer read strobe
//  pix_addr   out  clog2(N_PIX)          pixel index
//  pix_rdata  in   PIX_W                 pixel data, valid exactly 1 cycle after pix_rd_en
//  spk_we     out  1                     spike buffer write strobe
//  spk_addr   out  clog2(T_STEPS)        timestep index
//  spk_wdata  out  N_PIX                 spike word; bit i = pixel i
//  enc_busy   out  1                     high from job start until DONE inclusive
//  enc_done   out  1                     single-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; LFSR=LFSR_SEED; counters 0; spike shift register 0.
//  States: IDLE -> RD -> CMP -> (RD | WR) ; WR -> (RD | DONE) ; DONE -> HOLD ; HOLD -> IDLE.
//  IDLE: when enc_start=1, latch enc_mode, reload LFSR to LFSR_SEED, clear pixel and step counters, go to RD.
//  RD: pix_rd_en=1 and pix_addr=pix counter, for one cycle. Go to CMP.
//  CMP: sample pix_rdata and compute the spike bit:
//    rate mode: spike = (pix_rdata > lfsr[PIX_W-1:0]), unsigned compare.
//    threshold mode: spike = (pix_rdata >= THRESH).
//    Store the bit at spike-word bit position pix. In rate mode the LFSR advances once in every CMP cycle; in threshold mode it is frozen.
//    If pix == N_PIX-1: go to WR; otherwise pix++ and go to RD.
//  WR: spk_we=1, spk_addr=step, spk_wdata=assembled word, for one cycle. pix returns to 0.
//    If step == T_STEPS-1: go to DONE; otherwise step++ and go to RD.
//  DONE: enc_done=1 for exactly one cycle; enc_busy is still 1 in this cycle. Go to HOLD.
//  HOLD: enc_busy=0. Stay while enc_start=1; go to IDLE when enc_start=0. This prevents a held level start from retriggering.
//  LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
//    Shift left; new bit0 = l[15]^l[13]^l[12]^l[10].
//  Latency: from enc_start sampled in IDLE to enc_done = T_STEPS*(2*N_PIX+1)+1 cycles. Default: 265 cycles.
//  enc_busy=1 in RD, CMP, WR and DONE.
//  enc_start changes (drop or reassert) while busy: ignored; the job runs to completion.
//  enc_mode changes while busy: ignored.
//  rst asserted mid-job: state returns to IDLE on the next edge.
//    No enc_done is produced; no further spk_we occurs.
//    Spike words already written are not cleared.
//  Counters never wrap past N_PIX-1 or T_STEPS-1. Address outputs are 0 whenever their strobe is 0.
// TESTING
//  1. All pixels 0, mode 00 -> 8 writes, spk_wdata=16'h0000 each at addr 0..7; enc_done exactly 265 cycles after start.
//  2. All pixels 255, mode 01 -> every spk_wdata=16'hFFFF; the LFSR value is unchanged after the job.
//  3. Pixels alternating 100/200, mode 01 -> every word=16'hAAAA (odd pixel indices =200 spike).
//  4. Mode 00 with a ramp image, compared against a bit-exact LFSR reference model -> all 8 words match; a rerun gives identical words (reseed).
//  5. enc_start held high 20 cycles after enc_done -> no second job; then a low-high pulse starts a new job and produces 8 more writes.
//  6. rst pulsed during step 3 -> no enc_done and no spk_we afterwards; outputs 0; a subsequent start runs a full correct job.

Source files
------------

// File: rtl/snn_rate_encoder.sv
// Spike encoder: turns an N_PIX-pixel frame into T_STEPS spike words.
// Stochastic rate coding compares each pixel with an LFSR; threshold coding compares it with THRESH.
module snn_rate_encoder #(
  parameter int unsigned N_PIX     = 16,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned T_STEPS   = 8,
  parameter int unsigned THRESH    = 128,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned PA_W = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  localparam int unsigned SA_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_start,
  input  logic [1:0]       enc_mode,
  output logic             pix_rd_en,
  output logic [PA_W-1:0]  pix_addr,
  input  logic [PIX_W-1:0] pix_rdata,
  output logic             spk_we,
  output logic [SA_W-1:0]  spk_addr,
  output logic [N_PIX-1:0] spk_wdata,
  output logic             enc_busy,
  output logic             enc_done
);

  typedef enum logic [2:0] {IDLE, RD, CMP, WR, DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [PA_W-1:0]  pix_q, pix_d;
  logic [SA_W-1:0]  step_q, step_d;
  logic [N_PIX-1:0] word_q, word_d;

  logic             pix_rd_en_q, pix_rd_en_d;
  logic [PA_W-1:0]  pix_addr_q, pix_addr_d;
  logic             spk_we_q, spk_we_d;
  logic [SA_W-1:0]  spk_addr_q, spk_addr_d;
  logic [N_PIX-1:0] spk_wdata_q, spk_wdata_d;
  logic             enc_busy_q, enc_busy_d;
  logic             enc_done_q, enc_done_d;

  logic             rate_mode;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic spike_bit(input logic [PIX_W-1:0] pix,
                                     input logic [15:0]      lfsr,
                                     input logic             rate);
    if (rate) return (pix > lfsr[PIX_W-1:0]);
    return (32'(pix) >= THRESH);
  endfunction

  // Modes 10 and 11 fall back to rate coding.
  assign rate_mode = (mode_q != 2'b01);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    pix_d       = pix_q;
    step_d      = step_q;
    word_d      = word_q;
    pix_rd_en_d = 1'b0;
    pix_addr_d  = '0;
    spk_we_d    = 1'b0;
    spk_addr_d  = '0;
    spk_wdata_d = '0;
    enc_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc_start) begin
          mode_d      = enc_mode;
          lfsr_d      = LFSR_SEED;
          pix_d       = '0;
          step_d      = '0;
          word_d      = '0;
          state_d     = RD;
          pix_rd_en_d = 1'b1;
        end
      end
      RD: state_d = CMP;
      CMP: begin
        word_d[pix_q] = spike_bit(pix_rdata, lfsr_q, rate_mode);
        if (rate_mode) lfsr_d = lfsr_next(lfsr_q);
        if (pix_q == PA_W'(N_PIX - 1)) begin
          state_d     = WR;
          spk_we_d    = 1'b1;
          spk_addr_d  = step_q;
          spk_wdata_d = word_d;
        end else begin
          pix_d       = pix_q + 1'b1;
          state_d     = RD;
          pix_rd_en_d = 1'b1;
          pix_addr_d  = pix_d;
        end
      end
      WR: begin
        pix_d = '0;
        if (step_q == SA_W'(T_STEPS - 1)) begin
          state_d    = DONE;
          enc_done_d = 1'b1;
        end else begin
          step_d      = step_q + 1'b1;
          state_d     = RD;
          pix_rd_en_d = 1'b1;
        end
      end
      DONE: state_d = HOLD;
      // A start level still held from the finished job must not retrigger.
      HOLD: if (!enc_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enc_busy_d = (state_d == RD) || (state_d == CMP) || (state_d == WR) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 2'b00;
      lfsr_q      <= LFSR_SEED;
      pix_q       <= '0;
      step_q      <= '0;
      word_q      <= '0;
      pix_rd_en_q <= 1'b0;
      pix_addr_q  <= '0;
      spk_we_q    <= 1'b0;
      spk_addr_q  <= '0;
      spk_wdata_q <= '0;
      enc_busy_q  <= 1'b0;
      enc_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      pix_q       <= pix_d;
      step_q      <= step_d;
      word_q      <= word_d;
      pix_rd_en_q <= pix_rd_en_d;
      pix_addr_q  <= pix_addr_d;
      spk_we_q    <= spk_we_d;
      spk_addr_q  <= spk_addr_d;
      spk_wdata_q <= spk_wdata_d;
      enc_busy_q  <= enc_busy_d;
      enc_done_q  <= enc_done_d;
    end
  end

  assign pix_rd_en = pix_rd_en_q;
  assign pix_addr  = pix_addr_q;
  assign spk_we    = spk_we_q;
  assign spk_addr  = spk_addr_q;
  assign spk_wdata = spk_wdata_q;
  assign enc_busy  = enc_busy_q;
  assign enc_done  = enc_done_q;

endmodule
